// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the data port and the external memory bus of
//   mem_port_arbiter.
//   Modports:
//     master : the arbiter's view. It takes port requests and bus_ack/bus_rdata,
//              and drives stalls, rdata and the bus_* outputs.
//     slave  : the environment's view (core pipeline plus memory), mirrored.
//   Signals:
//     i_req/i_addr -> i_rdata/i_stall                     fetch port
//     d_req/d_we/d_size/d_addr/d_wdata -> d_rdata/d_stall data port
//     bus_req/we/size/addr/wdata/err -> bus_ack/bus_rdata memory bus
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              bus_req;
    logic              bus_we;
    logic [2:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_stall,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_rdata, d_stall,
        output bus_req, bus_we, bus_size, bus_addr, bus_wdata, bus_err,
        input  bus_ack, bus_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_stall,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_rdata, d_stall,
        input  bus_req, bus_we, bus_size, bus_addr, bus_wdata, bus_err,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory bus between the instruction-fetch port and the
//   data port. Data has fixed priority (older instruction). Each port's stall
//   stays high until its own transfer has completed; the DONE state lasts one
//   cycle so the pipeline advances exactly once per transfer.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-low reset
//     io   : mem_port_arbiter_if.master (fetch port, data port, memory bus)
//   Optional feature (macro ARB_TIMEOUT_EN): a watchdog ends a BUSY state after
//   TIMEOUT cycles without bus_ack, returns 32'hDEAD_BEEF to the owner (reads
//   only) and sets the sticky bus_err flag. Without it bus_err is tied 0.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master io
);
    typedef enum logic [2:0] {IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE} state_e;

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [2:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            bus_err_q, bus_err_d;
    logic            wd_expired;

    // The counter holds 0 during the first BUSY cycle, so TIMEOUT-1 marks the
    // TIMEOUT-th BUSY cycle.
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
        wd_d        = wd_q;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (io.d_req) begin
                    state_d     = D_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = io.d_we;
                    bus_size_d  = io.d_size;
                    bus_addr_d  = io.d_addr;
                    bus_wdata_d = io.d_wdata;
`ifdef ARB_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end else if (io.i_req) begin
                    state_d     = I_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_size_d  = 3'b000;
                    bus_addr_d  = io.i_addr;
                    bus_wdata_d = '0;
`ifdef ARB_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end
            end
            D_BUSY: begin
                if (io.bus_ack) begin
                    if (!bus_we_q) d_rdata_d = io.bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = D_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    if (!bus_we_q) d_rdata_d = ERR_DATA;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = D_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            I_BUSY: begin
                if (io.bus_ack) begin
                    i_rdata_d = io.bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = I_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    i_rdata_d = ERR_DATA;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = I_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            D_DONE:  state_d = IDLE;
            I_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_size_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_q        <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
            wd_q        <= wd_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    // Stalls are combinational so a port sees its DONE cycle immediately;
    // gating with rst keeps them low while reset is asserted.
    assign io.i_stall   = rst & io.i_req & (state_q != I_DONE);
    assign io.d_stall   = rst & io.d_req & (state_q != D_DONE);
    assign io.i_rdata   = i_rdata_q;
    assign io.d_rdata   = d_rdata_q;
    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_size  = bus_size_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_wdata = bus_wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign io.bus_err   = bus_err_q;
`else
    assign io.bus_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter. The driver issues port requests and
//   queues the bus transfers they must cause (data before fetch). A memory
//   responder compares each transfer, acks after a random latency and queues the
//   rdata each port must see and the cycle it must complete in. A separate
//   monitor compares port completions against that queue.
module tb_mem_port_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bif.master)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } comp_t;

    xfer_t       exp_bus[$];
    comp_t       comp_i[$];
    comp_t       comp_d[$];
    logic [31:0] model_i   = '0;
    logic [31:0] model_d   = '0;
    bit          model_err = 1'b0;

    int          force_lat   = -1;
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rd    = '0;

    // Records what a port must present one cycle after its transfer ends.
    function automatic void end_xfer(input xfer_t x, input logic [31:0] data);
        if (x.is_d) begin
            if (!x.we) model_d = data;
            comp_d.push_back('{cyc + 1, model_d});
        end else begin
            model_i = data;
            comp_i.push_back('{cyc + 1, model_i});
        end
    endfunction

    // Memory responder: acts 2 time units after each rising edge.
    initial begin : responder
        bit          active;
        bit          prev_end;
        int unsigned n;
        int unsigned lat;
        logic [31:0] rd;
        xfer_t       cur;
        active = 0; prev_end = 0; n = 0; lat = 0;
        cur = '{0, 0, 3'b000, 32'h0, 32'h0};
        bif.bus_ack = 1'b0;
        bif.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bif.bus_ack = 1'b0;
            if (!rst) begin
                active = 0;
                prev_end = 0;
            end else begin
                if (prev_end) begin
                    check("bus_req_drop", {31'b0, bif.bus_req}, 32'd0);
                    prev_end = 0;
                end else if (!active && bif.bus_req) begin
                    if (exp_bus.size() == 0) begin
                        check("unexpected_xfer", {31'b0, bif.bus_req}, 32'd0);
                        cur = '{0, 0, 3'b000, 32'h0, 32'h0};
                    end else begin
                        cur = exp_bus.pop_front();
                        check("bus_we", {31'b0, bif.bus_we}, {31'b0, cur.we});
                        check("bus_size", {29'b0, bif.bus_size}, {29'b0, cur.size});
                        check("bus_addr", bif.bus_addr, cur.addr);
                        if (cur.is_d && cur.we) check("bus_wdata", bif.bus_wdata, cur.wdata);
                    end
                    active = 1;
                    n = 0;
                    lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                end else if (active) begin
                    check("bus_req_hold", {31'b0, bif.bus_req}, 32'd1);
                end
                if (active) begin
                    n++;
                    if (n == lat + 1) begin
                        rd = force_rd_en ? force_rd : $urandom;
                        bif.bus_ack = 1'b1;
                        bif.bus_rdata = rd;
                        end_xfer(cur, rd);
                        active = 0;
                        prev_end = 1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (n == TB_TIMEOUT) begin
                        end_xfer(cur, 32'hDEAD_BEEF);
                        model_err = 1;
                        active = 0;
                        prev_end = 1;
                    end
`endif
                end else if ($urandom_range(0, 7) == 0) begin
                    // Stray ack while no transfer is in flight; must be ignored.
                    bif.bus_ack = 1'b1;
                    bif.bus_rdata = $urandom;
                end
            end
        end
    end

    // Completion monitor: a port completes when req is high and stall is low.
    initial begin : monitor
        bit    done_i, due_i, done_d, due_d;
        comp_t c;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_i = bif.i_req && !bif.i_stall;
                due_i  = (comp_i.size() > 0) && (comp_i[0].due == cyc);
                if (done_i || due_i) begin
                    check("i_done_cycle", {31'b0, done_i}, {31'b0, due_i});
                    if (due_i) begin
                        c = comp_i.pop_front();
                        if (done_i) begin
                            check("i_rdata", bif.i_rdata, c.data);
                            check("bus_err", {31'b0, bif.bus_err}, {31'b0, model_err});
                        end
                    end
                end
                done_d = bif.d_req && !bif.d_stall;
                due_d  = (comp_d.size() > 0) && (comp_d[0].due == cyc);
                if (done_d || due_d) begin
                    check("d_done_cycle", {31'b0, done_d}, {31'b0, due_d});
                    if (due_d) begin
                        c = comp_d.pop_front();
                        if (done_d) begin
                            check("d_rdata", bif.d_rdata, c.data);
                            check("bus_err", {31'b0, bif.bus_err}, {31'b0, model_err});
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic do_txn(input bit di, input bit dd, input logic [31:0] ia, input bit we,
                          input logic [2:0] sz, input logic [31:0] da, input logic [31:0] wd,
                          output int unsigned done_cyc);
        bit          i_pend, d_pend;
        int unsigned budget;
        bif.i_req   = di;
        bif.i_addr  = ia;
        bif.d_req   = dd;
        bif.d_we    = we;
        bif.d_size  = sz;
        bif.d_addr  = da;
        bif.d_wdata = wd;
        if (dd) exp_bus.push_back('{1, we, sz, da, wd});
        if (di) exp_bus.push_back('{0, 0, 3'b000, ia, 32'h0});
        i_pend = di;
        d_pend = dd;
        budget = 0;
        done_cyc = 0;
        while ((i_pend || d_pend) && budget < 200) begin
            @(negedge clk);
            budget++;
            if (i_pend && !bif.i_stall) begin i_pend = 0; done_cyc = cyc; end
            if (d_pend && !bif.d_stall) begin d_pend = 0; done_cyc = cyc; end
            step();
            if (!i_pend) begin bif.i_req = 1'b0; bif.i_addr = $urandom; end
            if (!d_pend) begin bif.d_req = 1'b0; bif.d_addr = $urandom; bif.d_wdata = $urandom; end
        end
        if (i_pend || d_pend) begin
            check("txn_timeout", {31'b0, bif.i_stall | bif.d_stall}, 32'd0);
            bif.i_req = 1'b0;
            bif.d_req = 1'b0;
        end
    endtask

    initial begin : stim
        int unsigned dc, prev_dc;
        int unsigned mode, budget;
        bif.i_req = 0; bif.i_addr = '0;
        bif.d_req = 0; bif.d_we = 0; bif.d_size = '0; bif.d_addr = '0; bif.d_wdata = '0;

        // Reset state, with both requests asserted while reset is low.
        repeat (2) step();
        bif.i_req = 1'b1;
        bif.d_req = 1'b1;
        #1;
        check("rst_i_stall", {31'b0, bif.i_stall}, 32'd0);
        check("rst_d_stall", {31'b0, bif.d_stall}, 32'd0);
        check("rst_bus_req", {31'b0, bif.bus_req}, 32'd0);
        check("rst_bus_we", {31'b0, bif.bus_we}, 32'd0);
        check("rst_bus_addr", bif.bus_addr, 32'd0);
        check("rst_i_rdata", bif.i_rdata, 32'd0);
        check("rst_d_rdata", bif.d_rdata, 32'd0);
        check("rst_bus_err", {31'b0, bif.bus_err}, 32'd0);
        bif.i_req = 1'b0;
        bif.d_req = 1'b0;
        rst = 1'b1;
        step();

        // Fetch only, ack on the second bus_req cycle.
        force_lat = 1; force_rd_en = 1; force_rd = 32'h2408_0005;
        do_txn(1, 0, 32'h0000_0040, 0, 3'b000, 32'h0, 32'h0, dc);
        check("fetch_rdata", bif.i_rdata, 32'h2408_0005);
        force_lat = -1; force_rd_en = 0;

        // Simultaneous requests: data first.
        do_txn(1, 1, 32'h0000_0080, 0, 3'b010, 32'h0000_0100, 32'h0, dc);

        // Store: d_rdata must keep its previous value.
        do_txn(0, 1, 32'h0, 1, 3'b010, 32'h0000_0200, 32'hA5A5_A5A5, dc);

        // Back-to-back fetches with immediate ack complete every 3 cycles.
        force_lat = 0;
        prev_dc = 0;
        for (int k = 0; k < 3; k++) begin
            do_txn(1, 0, $urandom & 32'hFFFF_FFFC, 0, 3'b000, 32'h0, 32'h0, dc);
            if (k > 0) check("b2b_spacing", dc - prev_dc, 32'd3);
            prev_dc = dc;
        end
        force_lat = -1;

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) step();
            mode = $urandom_range(1, 3);
            do_txn(mode[0], mode[1], $urandom & 32'hFFFF_FFFC, 1'($urandom),
                   3'($urandom), $urandom, $urandom, dc);
        end

        // Reset during a data transfer.
        force_lat = 1000;
        bif.d_req = 1; bif.d_we = 0; bif.d_size = 3'b010; bif.d_addr = 32'h0000_0300;
        exp_bus.push_back('{1, 0, 3'b010, 32'h0000_0300, bif.d_wdata});
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!bif.bus_req && budget < 10);
        check("mid_bus_req_up", {31'b0, bif.bus_req}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_bus_req", {31'b0, bif.bus_req}, 32'd0);
        check("mid_rst_d_stall", {31'b0, bif.d_stall}, 32'd0);
        check("mid_rst_d_rdata", bif.d_rdata, 32'd0);
        exp_bus.delete(); comp_i.delete(); comp_d.delete();
        model_i = '0; model_d = '0; model_err = 0;
        step();
        bif.d_req = 1'b0;
        step();
        rst = 1'b1;
        force_lat = -1;
        step();
        do_txn(0, 1, 32'h0, 0, 3'b010, 32'h0000_0400, 32'h0, dc);

`ifdef ARB_TIMEOUT_EN
        // No ack: watchdog ends the load with the error pattern.
        force_lat = 1000;
        do_txn(0, 1, 32'h0, 0, 3'b010, 32'h0000_0500, 32'h0, dc);
        check("timeout_rdata", bif.d_rdata, 32'hDEAD_BEEF);
        check("timeout_err", {31'b0, bif.bus_err}, 32'd1);
        force_lat = -1;
        do_txn(1, 0, 32'h0000_0600, 0, 3'b000, 32'h0, 32'h0, dc);
        check("err_sticky", {31'b0, bif.bus_err}, 32'd1);
`else
        check("err_tied", {31'b0, bif.bus_err}, 32'd0);
`endif

        repeat (4) step();
        check("bus_queue_empty", exp_bus.size(), 32'd0);
        check("comp_queue_empty", comp_i.size() + comp_d.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : global_limit
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
